axi4_lite_sram_slave: RTL
=========================

Name: axi4_lite_sram_slave

Overview:
AXI4-Lite slave that terminates the five channels driven by the core's AXI4-Lite master and backs them with a word-addressed on-chip SRAM.
- Sits directly downstream of the master; it is the consumer of AR/AW/W and the producer of R/B.
- Independent read and write FSMs.
- Configurable read latency, byte-strobe writes, DECERR for out-of-window addresses.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- MASK_WIDTH, 4, strobe width (DATA_WIDTH/8).
- RESP_WIDTH, 2, response width.
- BASE_ADDR, 32'h8000_0000, first byte address of the window.
- MEM_WORDS, 1024, depth in words; window is BASE_ADDR .. BASE_ADDR+4*MEM_WORDS-1.
- RD_LATENCY, 1, cycles from AR handshake to RVALID assertion (legal range 1..15).

Ports:
- iClock  in  1  clock.
- iReset  in  1  reset; asynchronous, active-high.
- pAXI4S_ar_valid  in  1  read address valid.
- pAXI4S_ar_ready  out  1  read address ready.
- pAXI4S_ar_bits_addr  in  ADDR_WIDTH  read byte address.
- pAXI4S_r_valid  out  1  read data valid.
- pAXI4S_r_ready  in  1  read data ready.
- pAXI4S_r_bits_data  out  DATA_WIDTH  read data.
- pAXI4S_r_bits_resp  out  RESP_WIDTH  read response.
- pAXI4S_aw_valid  in  1  write address valid.
- pAXI4S_aw_ready  out  1  write address ready.
- pAXI4S_aw_bits_addr  in  ADDR_WIDTH  write byte address.
- pAXI4S_w_valid  in  1  write data valid.
- pAXI4S_w_ready  out  1  write data ready.
- pAXI4S_w_bits_data  in  DATA_WIDTH  write data.
- pAXI4S_w_bits_strb  in  MASK_WIDTH  byte strobes.
- pAXI4S_b_valid  out  1  write response valid.
- pAXI4S_b_ready  in  1  write response ready.
- pAXI4S_b_bits_resp  out  RESP_WIDTH  write response.

Behaviour:
- Reset (asynchronous, iReset=1):
  - All outputs low or zero except ar_ready, aw_ready and w_ready, which are 1.
  - Both FSMs return to IDLE and the latency counter clears.
  - A transfer in flight when reset asserts is dropped with no response.
  - SRAM contents are not reset.
- Address decode: in-range when BASE_ADDR <= addr < BASE_ADDR+4*MEM_WORDS. Word index = (addr-BASE_ADDR)>>2. addr[1:0] is ignored, with no alignment error.
- Read FSM:
  - RD_IDLE: ar_ready=1. On ar_valid&&ar_ready, latch the address, load the counter with RD_LATENCY-1, go to RD_WAIT.
  - RD_WAIT: ar_ready=0. Decrement the counter. At 0, sample SRAM (or 0 if out of range), set resp OKAY=2'b00 or DECERR=2'b11, go to RD_RESP.
  - RD_RESP: r_valid=1. Data and resp are held stable until r_ready. On r_valid&&r_ready go to RD_IDLE; r_valid is low the next cycle.
  - Minimum handshake-to-RVALID latency is RD_LATENCY cycles; back-to-back reads are spaced by at least 1 idle cycle.
- Write FSM:
  - WR_IDLE: aw_ready=1 and w_ready=1.
    - AW and W are captured independently, in any order, possibly in the same cycle.
    - Each ready drops for that channel once captured.
    - When both are captured, go to WR_EXEC.
  - WR_EXEC (1 cycle):
    - If in range, write the bytes whose strb bit is 1; resp=OKAY.
    - If out of range, no write; resp=DECERR.
    - strb=0 is a legal no-op with OKAY.
  - WR_RESP: b_valid=1, held until b_ready. Then return to WR_IDLE, with aw_ready and w_ready high next cycle.
- Simultaneous read sample and write commit to the same word: the read returns the old data (read-before-write).
- Reads and writes proceed concurrently; there is no ordering between channels.

Optional Feature:
- Macro AXI4_LITE_SLAVE_RAND_DELAY_EN.
- When defined:
  - A 16-bit LFSR (seed 16'hACE1, reset-loaded) adds 0..3 extra cycles, from LFSR[1:0], to each RD_WAIT.
  - An equal 0..3-cycle stall, from LFSR[3:2], is inserted before WR_RESP.
  - The LFSR advances every cycle.
- When undefined: latencies are exactly as specified above and no LFSR logic exists.

Decomposition:
- Shared package/include (Config.v):
  - width macros ADDR/DATA/MASK/RESP_WIDTH;
  - response codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - read and write FSM state encodings.
- One sub-module, axi4_lite_sram_mem:
  - single-clock, one synchronous read port and one byte-enable write port;
  - read-before-write on collision;
  - parameterised by MEM_WORDS and DATA_WIDTH.

Test Plan:
- Write then read, feature off, RD_LATENCY=1:
  - AW=0x8000_0010 with W=0xDEAD_BEEF, strb=4'hF -> B resp 2'b00.
  - AR 0x8000_0010 -> r_valid exactly 1 cycle after the AR handshake, data 0xDEAD_BEEF, resp 2'b00.
- Byte strobes: word at 0x8000_0020 = 0x1122_3344; write 0xAABB_CCDD with strb=4'b0101 -> readback 0x11BB_33DD.
- Channel order:
  - W presented 3 cycles before AW -> single write committed and one B pulse.
  - AW and W in the same cycle -> b_valid 2 cycles after the handshake.
- Decode error:
  - AR 0x7FFF_FFFC -> r_data 0, resp 2'b11.
  - AW 0x8000_1000 with MEM_WORDS=1024 -> B resp 2'b11, no SRAM word modified.
- Backpressure: hold r_ready=0 for 5 cycles -> r_valid, data and resp stable throughout; with b_ready=0, b_valid stays high and aw_ready/w_ready stay 0.
- Reset mid-transfer:
  - Assert iReset during RD_WAIT (RD_LATENCY=4) -> r_valid never rises.
  - After release, ar_ready=aw_ready=w_ready=1 immediately and a fresh read returns the correct data.

Source files
------------

// File: rtl/axi4_lite_sram_slave_pkg.sv
// Shared widths, AXI response codes and FSM state encodings for the AXI4-Lite SRAM slave.
package axi4_lite_sram_slave_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_MASK_W = AXI_DATA_W / 8;
  localparam int AXI_RESP_W = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_EXEC, WR_RESP} wr_state_t;

endpackage

// File: rtl/axi4_lite_sram_slave_mem.sv
// Word-addressed SRAM: one synchronous read port, one byte-enable write port.
// On a same-word collision the read port returns the pre-write contents.
module axi4_lite_sram_mem #(
  parameter int MEM_WORDS  = 1024,
  parameter int DATA_WIDTH = 32,
  localparam int IDX_W     = $clog2(MEM_WORDS),
  localparam int MASK_W    = DATA_WIDTH / 8
) (
  input  logic                  iClock,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [MASK_W-1:0]     wr_strb
);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  always_ff @(posedge iClock) begin
    if (rd_en)
      rd_data <= mem[rd_idx];
    if (wr_en)
      for (int i = 0; i < MASK_W; i++)
        if (wr_strb[i])
          mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
  end

endmodule

// File: rtl/axi4_lite_sram_slave.sv
// AXI4-Lite slave backed by on-chip SRAM, independent read and write FSMs.
// Optional macro AXI4_LITE_SLAVE_RAND_DELAY_EN adds LFSR-driven 0..3 cycle read/write stalls.
//
// state   | meaning
// RD_IDLE | accepting AR, ar_ready high
// RD_WAIT | latency down-counter running, SRAM sampled at terminal count
// RD_RESP | r_valid high, data/resp held until r_ready
// WR_IDLE | capturing AW and W independently
// WR_EXEC | committing strobed bytes (or skipping on DECERR)
// WR_RESP | b_valid high until b_ready
module axi4_lite_sram_slave
  import axi4_lite_sram_slave_pkg::*;
#(
  parameter int                    ADDR_WIDTH = AXI_ADDR_W,
  parameter int                    DATA_WIDTH = AXI_DATA_W,
  parameter int                    MASK_WIDTH = AXI_MASK_W,
  parameter int                    RESP_WIDTH = AXI_RESP_W,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    MEM_WORDS  = 1024,
  parameter int                    RD_LATENCY = 1
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  pAXI4S_ar_valid,
  output logic                  pAXI4S_ar_ready,
  input  logic [ADDR_WIDTH-1:0] pAXI4S_ar_bits_addr,
  output logic                  pAXI4S_r_valid,
  input  logic                  pAXI4S_r_ready,
  output logic [DATA_WIDTH-1:0] pAXI4S_r_bits_data,
  output logic [RESP_WIDTH-1:0] pAXI4S_r_bits_resp,
  input  logic                  pAXI4S_aw_valid,
  output logic                  pAXI4S_aw_ready,
  input  logic [ADDR_WIDTH-1:0] pAXI4S_aw_bits_addr,
  input  logic                  pAXI4S_w_valid,
  output logic                  pAXI4S_w_ready,
  input  logic [DATA_WIDTH-1:0] pAXI4S_w_bits_data,
  input  logic [MASK_WIDTH-1:0] pAXI4S_w_bits_strb,
  output logic                  pAXI4S_b_valid,
  input  logic                  pAXI4S_b_ready,
  output logic [RESP_WIDTH-1:0] pAXI4S_b_bits_resp
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = 5;
  localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(4 * MEM_WORDS);

  rd_state_t             rd_state;
  wr_state_t             wr_state;
  logic [ADDR_WIDTH-1:0] rd_addr, wr_addr, rd_off, wr_off;
  logic [DATA_WIDTH-1:0] wr_data, mem_rdata;
  logic [MASK_WIDTH-1:0] wr_strb;
  logic [CNT_W-1:0]      rd_cnt, rd_extra;
  logic                  rd_in, wr_in, rd_hit, rd_sample, wr_go, wr_commit;

  // Offset wraps to a large value below BASE_ADDR, so the upper compare alone rejects it too.
  assign rd_off    = rd_addr - BASE_ADDR;
  assign wr_off    = wr_addr - BASE_ADDR;
  assign rd_in     = (rd_addr >= BASE_ADDR) && (rd_off < WIN_BYTES);
  assign wr_in     = (wr_addr >= BASE_ADDR) && (wr_off < WIN_BYTES);
  assign rd_sample = (rd_state == RD_WAIT) && (rd_cnt == '0);
  assign wr_commit = (wr_state == WR_EXEC) && wr_go;

`ifdef AXI4_LITE_SLAVE_RAND_DELAY_EN
  logic [15:0] lfsr;
  logic [1:0]  wr_cnt;

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      lfsr   <= 16'hACE1;
      wr_cnt <= '0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (wr_state == WR_IDLE)
        wr_cnt <= lfsr[3:2];
      else if (wr_state == WR_EXEC && wr_cnt != '0)
        wr_cnt <= wr_cnt - 2'd1;
    end
  end

  assign rd_extra = {3'b000, lfsr[1:0]};
  assign wr_go    = (wr_cnt == '0);
`else
  assign rd_extra = '0;
  assign wr_go    = 1'b1;
`endif

  axi4_lite_sram_mem #(
    .MEM_WORDS  (MEM_WORDS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .iClock  (iClock),
    .rd_en   (rd_sample && rd_in),
    .rd_idx  (rd_off[IDX_W+1:2]),
    .rd_data (mem_rdata),
    .wr_en   (wr_commit && wr_in),
    .wr_idx  (wr_off[IDX_W+1:2]),
    .wr_data (wr_data),
    .wr_strb (wr_strb)
  );

  // SRAM output register is not reset; rd_hit masks it to zero after reset and on DECERR.
  assign pAXI4S_r_bits_data = rd_hit ? mem_rdata : '0;

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      rd_state           <= RD_IDLE;
      pAXI4S_ar_ready    <= 1'b1;
      pAXI4S_r_valid     <= 1'b0;
      pAXI4S_r_bits_resp <= '0;
      rd_addr            <= '0;
      rd_cnt             <= '0;
      rd_hit             <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE:
          if (pAXI4S_ar_valid && pAXI4S_ar_ready) begin
            rd_addr         <= pAXI4S_ar_bits_addr;
            rd_cnt          <= CNT_W'(RD_LATENCY - 1) + rd_extra;
            pAXI4S_ar_ready <= 1'b0;
            rd_state        <= RD_WAIT;
          end
        RD_WAIT:
          if (rd_cnt == '0) begin
            rd_hit             <= rd_in;
            pAXI4S_r_bits_resp <= rd_in ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_DECERR);
            pAXI4S_r_valid     <= 1'b1;
            rd_state           <= RD_RESP;
          end else begin
            rd_cnt <= rd_cnt - 1'b1;
          end
        RD_RESP:
          if (pAXI4S_r_ready) begin
            pAXI4S_r_valid  <= 1'b0;
            pAXI4S_ar_ready <= 1'b1;
            rd_state        <= RD_IDLE;
          end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      wr_state           <= WR_IDLE;
      pAXI4S_aw_ready    <= 1'b1;
      pAXI4S_w_ready     <= 1'b1;
      pAXI4S_b_valid     <= 1'b0;
      pAXI4S_b_bits_resp <= '0;
      wr_addr            <= '0;
      wr_data            <= '0;
      wr_strb            <= '0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (pAXI4S_aw_valid && pAXI4S_aw_ready) begin
            wr_addr         <= pAXI4S_aw_bits_addr;
            pAXI4S_aw_ready <= 1'b0;
          end
          if (pAXI4S_w_valid && pAXI4S_w_ready) begin
            wr_data        <= pAXI4S_w_bits_data;
            wr_strb        <= pAXI4S_w_bits_strb;
            pAXI4S_w_ready <= 1'b0;
          end
          if (!pAXI4S_aw_ready && !pAXI4S_w_ready)
            wr_state <= WR_EXEC;
        end
        WR_EXEC:
          if (wr_go) begin
            pAXI4S_b_bits_resp <= wr_in ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_DECERR);
            pAXI4S_b_valid     <= 1'b1;
            wr_state           <= WR_RESP;
          end
        WR_RESP:
          if (pAXI4S_b_ready) begin
            pAXI4S_b_valid  <= 1'b0;
            pAXI4S_aw_ready <= 1'b1;
            pAXI4S_w_ready  <= 1'b1;
            wr_state        <= WR_IDLE;
          end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

endmodule
